// File: rtl/pixel_scan_gen_if.sv
// -----------------------------------------------------------------------------
// pixel_scan_gen_if
//   Control and pixel-stream bundle for pixel_scan_gen. Signal names follow
//   the generator's view: i_* enter the generator and o_* leave it.
//
//   Parameters : ADDR_W  - linear framebuffer address width
//                COORD_W - output coordinate width
//   Modports   : master - the scan generator (consumes control, sources beats)
//                slave  - the controller / pixel consumer on the other side
//
//   i_start, i_abort       scan start / abort pulses
//   i_seek_valid/addr      resume-at-address request
//   i_ready                downstream accepts the current beat
//   o_valid/x/y/addr/last  current pixel beat
//   o_frame_done           pulse after the final beat of the frame is accepted
//   o_seek_err             pulse when a seek address is out of range
//   o_busy                 generator is not idle
// -----------------------------------------------------------------------------
interface pixel_scan_gen_if #(
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 16
);
  logic               i_start;
  logic               i_abort;
  logic               i_seek_valid;
  logic [ADDR_W-1:0]  i_seek_addr;
  logic               i_ready;
  logic               o_valid;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic [ADDR_W-1:0]  o_addr;
  logic               o_last;
  logic               o_frame_done;
  logic               o_seek_err;
  logic               o_busy;

  modport master (
    input  i_start, i_abort, i_seek_valid, i_seek_addr, i_ready,
    output o_valid, o_x, o_y, o_addr, o_last, o_frame_done, o_seek_err, o_busy
  );

  modport slave (
    output i_start, i_abort, i_seek_valid, i_seek_addr, i_ready,
    input  o_valid, o_x, o_y, o_addr, o_last, o_frame_done, o_seek_err, o_busy
  );
endinterface

// File: rtl/pixel_scan_gen.sv
// -----------------------------------------------------------------------------
// pixel_scan_gen
//   Raster pixel stream generator: walks addr = x + y*WIDTH from a start pixel
//   to the last pixel of the frame under valid/ready backpressure. A seek
//   request is split into (x, y) by a restoring divider (one quotient bit per
//   cycle, ADDR_W cycles) and the scan resumes from that pixel.
//
//   Ports : i_clk    - clock, rising edge
//           i_rst_n  - asynchronous reset, active-low
//           bus      - pixel_scan_gen_if.master (control + pixel stream)
//
//   Configuration macro PIXEL_SCAN_CENTER_EN:
//     defined   - o_x/o_y are centre-origin two's complement coordinates
//                 (x - WIDTH/2, y - HEIGHT/2)
//     undefined - o_x/o_y are unsigned raster coordinates
// -----------------------------------------------------------------------------
module pixel_scan_gen #(
  parameter int WIDTH   = 800,
  parameter int HEIGHT  = 600,
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pixel_scan_gen_if.master  bus
);

  localparam int                 CNT_W      = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0]   LP_CNT_END = CNT_W'(ADDR_W - 1);
  localparam logic [ADDR_W-1:0]  LP_LAST    = ADDR_W'(WIDTH * HEIGHT - 1);
  // One extra bit so a frame filling the whole address space still compares.
  localparam logic [ADDR_W:0]    LP_NPIX    = (ADDR_W + 1)'(WIDTH * HEIGHT);
  localparam logic [ADDR_W:0]    LP_DIVISOR = (ADDR_W + 1)'(WIDTH);
  localparam logic [COORD_W-1:0] LP_X_MAX   = COORD_W'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_SCAN} state_t;

  state_t             r_state, w_state_next;
  logic [COORD_W-1:0] r_x, r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_div;      // dividend shifting out, quotient shifting in
  logic [ADDR_W-1:0]  r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_seek_err, r_frame_done;

  logic               w_start_scan, w_seek_acc, w_seek_rej, w_beat_acc, w_frame_end;
  logic               w_seek_in_range;
  logic [ADDR_W:0]    w_rem_sh;
  logic               w_q_bit;
  logic [ADDR_W-1:0]  w_rem_next, w_div_next;

  assign w_seek_in_range = {1'b0, bus.i_seek_addr} < LP_NPIX;

  // Restoring division step: bring down the next dividend bit, subtract the
  // divisor when it fits and record a 1 in the quotient.
  assign w_rem_sh   = {r_rem, r_div[ADDR_W-1]};
  assign w_q_bit    = (w_rem_sh >= LP_DIVISOR);
  assign w_rem_next = w_q_bit ? ADDR_W'(w_rem_sh - LP_DIVISOR) : ADDR_W'(w_rem_sh);
  assign w_div_next = {r_div[ADDR_W-2:0], w_q_bit};

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_start_scan = 1'b0;
    w_seek_acc   = 1'b0;
    w_seek_rej   = 1'b0;
    w_beat_acc   = 1'b0;
    w_frame_end  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          // start wins over a simultaneous seek; the seek is silently dropped
          w_state_next = ST_SCAN;
          w_start_scan = 1'b1;
        end else if (bus.i_seek_valid) begin
          if (w_seek_in_range) begin
            w_state_next = ST_DIV;
            w_seek_acc   = 1'b1;
          end else begin
            w_seek_rej   = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (bus.i_abort)              w_state_next = ST_IDLE;
        else if (r_cnt == LP_CNT_END) w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (bus.i_abort) begin
          w_state_next = ST_IDLE;
        end else if (bus.i_ready) begin
          w_beat_acc = 1'b1;
          if (r_addr == LP_LAST) begin
            w_state_next = ST_IDLE;
            w_frame_end  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_div        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_seek_err   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_seek_err   <= w_seek_rej;
      r_frame_done <= w_frame_end;

      if (w_start_scan) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end

      if (w_seek_acc) begin
        r_addr <= bus.i_seek_addr;
        r_div  <= bus.i_seek_addr;
        r_rem  <= '0;
        r_cnt  <= '0;
      end

      if (r_state == ST_DIV) begin
        r_div <= w_div_next;
        r_rem <= w_rem_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_state_next == ST_SCAN) begin
          r_x <= COORD_W'(w_rem_next);
          r_y <= COORD_W'(w_div_next);
        end
      end

      // The final beat leaves the counters parked on the last pixel.
      if (w_beat_acc && !w_frame_end) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_x == LP_X_MAX) begin
          r_x <= '0;
          r_y <= r_y + COORD_W'(1);
        end else begin
          r_x <= r_x + COORD_W'(1);
        end
      end
    end
  end

  assign bus.o_valid      = (r_state == ST_SCAN);
  assign bus.o_busy       = (r_state != ST_IDLE);
  assign bus.o_addr       = r_addr;
  assign bus.o_last       = (r_addr == LP_LAST) && bus.o_valid;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_seek_err   = r_seek_err;

`ifdef PIXEL_SCAN_CENTER_EN
  assign bus.o_x = r_x - COORD_W'(WIDTH / 2);
  assign bus.o_y = r_y - COORD_W'(HEIGHT / 2);
`else
  assign bus.o_x = r_x;
  assign bus.o_y = r_y;
`endif

endmodule

// File: tb/tb_pixel_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_pixel_scan_gen
//   Directed self-checking bench for pixel_scan_gen (800x600 frame, 19-bit
//   addresses). Inputs change and outputs are sampled on the falling edge.
//   Expected coordinates follow PIXEL_SCAN_CENTER_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_pixel_scan_gen;
  localparam int ADDR_W  = 19;
  localparam int COORD_W = 16;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pixel_scan_gen_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus ();

  pixel_scan_gen #(
    .WIDTH(800), .HEIGHT(600), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ex_x(input int x);
`ifdef PIXEL_SCAN_CENTER_EN
    return 16'(x - 400);
`else
    return 16'(x);
`endif
  endfunction

  function automatic logic [15:0] ex_y(input int y);
`ifdef PIXEL_SCAN_CENTER_EN
    return 16'(y - 300);
`else
    return 16'(y);
`endif
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int x, input int y, input int addr);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, ".x"},     32'(bus.o_x),     32'(ex_x(x)));
    check({tag, ".y"},     32'(bus.o_y),     32'(ex_y(y)));
    check({tag, ".addr"},  32'(bus.o_addr),  32'(addr));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(bus.o_valid),      32'd0);
    check({tag, ".busy"},  32'(bus.o_busy),       32'd0);
    check({tag, ".fdone"}, 32'(bus.o_frame_done), 32'd0);
  endtask

  // Advance with i_ready=1 until o_addr reaches the target or the budget runs out.
  task automatic run_to(input string tag, input int addr, input int budget);
    int n = 0;
    while (bus.o_addr != ADDR_W'(addr) && n < budget) begin
      tick();
      n++;
    end
    check({tag, ".reached"}, 32'(bus.o_addr), 32'(addr));
  endtask

  task automatic pulse_abort();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
  endtask

  task automatic seek(input int addr);
    bus.i_seek_valid = 1'b1;
    bus.i_seek_addr  = ADDR_W'(addr);
    tick();
    bus.i_seek_valid = 1'b0;
    bus.i_seek_addr  = '0;
  endtask

  initial begin
    int beats;
    int n;
    int seen;
    int early_fd;

    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_seek_valid = 1'b0;
    bus.i_seek_addr  = '0;
    bus.i_ready      = 1'b1;

    // ---- reset --------------------------------------------------------------
    tick(); tick();
    check("rst_hold.valid", 32'(bus.o_valid), 32'd0);
    check("rst_hold.busy",  32'(bus.o_busy),  32'd0);
    i_rst_n = 1'b1;
    tick();
    check("rst.valid",  32'(bus.o_valid),      32'd0);
    check("rst.x",      32'(bus.o_x),          32'(ex_x(0)));
    check("rst.y",      32'(bus.o_y),          32'(ex_y(0)));
    check("rst.addr",   32'(bus.o_addr),       32'd0);
    check("rst.last",   32'(bus.o_last),       32'd0);
    check("rst.fdone",  32'(bus.o_frame_done), 32'd0);
    check("rst.seekerr",32'(bus.o_seek_err),   32'd0);
    check("rst.busy",   32'(bus.o_busy),       32'd0);

    // ---- start scan, backpressure, line wrap, abort --------------------------
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_beat("start.b0", 0, 0, 0);
    check("start.busy", 32'(bus.o_busy), 32'd1);
    check("start.last", 32'(bus.o_last), 32'd0);
    repeat (5) tick();
    check_beat("bp.at5", 5, 0, 5);
    bus.i_ready = 1'b0;
    tick(); check_beat("bp.hold1", 5, 0, 5);
    tick(); check_beat("bp.hold2", 5, 0, 5);
    tick(); check_beat("bp.hold3", 5, 0, 5);
    bus.i_ready = 1'b1;
    tick();
    check_beat("bp.resume", 6, 0, 6);
    run_to("wrap", 800, 900);
    check_beat("wrap.b800", 0, 1, 800);
    run_to("abort_pt", 2410, 2000);
    check_beat("abort_pt.b2410", 10, 3, 2410);
    pulse_abort();
    check_idle("scan_abort");
    tick();
    check("scan_abort.fdone_late", 32'(bus.o_frame_done), 32'd0);

    // ---- seek 1601: ADDR_W cycles of divide, then (1,2,1601) ----------------
    seek(1601);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("div.cyc%0d", i), {30'd0, bus.o_busy, bus.o_valid}, 32'b10);
      tick();
    end
    check_beat("seek1601.first", 1, 2, 1601);
    tick();
    check_beat("seek1601.next", 2, 2, 1602);
    pulse_abort();
    check_idle("seek1601.abort");

    // ---- out-of-range seek, start+seek, abort ignored in idle ----------------
    seek(480000);
    check("seekerr.pulse", 32'(bus.o_seek_err), 32'd1);
    check_idle("seekerr.idle");
    tick();
    check("seekerr.clear", 32'(bus.o_seek_err), 32'd0);
    check("seekerr.busy",  32'(bus.o_busy),     32'd0);

    bus.i_start      = 1'b1;
    bus.i_seek_valid = 1'b1;
    bus.i_seek_addr  = ADDR_W'(799);
    tick();
    bus.i_start      = 1'b0;
    bus.i_seek_valid = 1'b0;
    bus.i_seek_addr  = '0;
    check_beat("start_wins.b0", 0, 0, 0);
    check("start_wins.seekerr", 32'(bus.o_seek_err), 32'd0);
    tick();
    check_beat("start_wins.b1", 1, 0, 1);
    pulse_abort();
    check_idle("start_wins.abort");

    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check_beat("idle_abort_ignored", 0, 0, 0);
    pulse_abort();
    check_idle("idle_abort_ignored.end");

    // ---- abort during divide: no beat ever appears ---------------------------
    seek(100);
    repeat (5) tick();
    check("divabort.busy_before", 32'(bus.o_busy), 32'd1);
    pulse_abort();
    check_idle("divabort");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.o_valid) seen++;
      tick();
    end
    check("divabort.no_beat", 32'(seen), 32'd0);

    // ---- centre of frame: addr 240400 is (400,300) --------------------------
    seek(240400);
    n = 0;
    while (!bus.o_valid && n < 40) begin tick(); n++; end
    check_beat("centre", 400, 300, 240400);
    pulse_abort();

    // ---- end of frame: last beat, frame_done, beat count ---------------------
    seek(479990);
    n = 0;
    while (!bus.o_valid && n < 40) begin tick(); n++; end
    check_beat("eof.first", 790, 599, 479990);
    check("eof.first.last", 32'(bus.o_last), 32'd0);
    beats    = 0;
    early_fd = 0;
    n        = 0;
    while (!bus.o_last && n < 40) begin
      if (bus.o_valid)      beats++;
      if (bus.o_frame_done) early_fd++;
      tick();
      n++;
    end
    beats++;
    check_beat("eof.last", 799, 599, 479999);
    check("eof.last.flag",  32'(bus.o_last), 32'd1);
    check("eof.beats",      32'(beats),      32'd10);
    check("eof.early_fd",   32'(early_fd),   32'd0);
    bus.i_ready = 1'b0;
    tick();
    check("eof.bp.last",  32'(bus.o_last),       32'd1);
    check("eof.bp.fdone", 32'(bus.o_frame_done), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    check("eof.done.valid", 32'(bus.o_valid),      32'd0);
    check("eof.done.pulse", 32'(bus.o_frame_done), 32'd1);
    check("eof.done.busy",  32'(bus.o_busy),       32'd0);
    check("eof.done.last",  32'(bus.o_last),       32'd0);
    tick();
    check("eof.done.clear", 32'(bus.o_frame_done), 32'd0);

    // ---- reset asserted mid-scan --------------------------------------------
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (7) tick();
    check_beat("midrst.before", 7, 0, 7);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(bus.o_valid), 32'd0);
    check("midrst.busy",  32'(bus.o_busy),  32'd0);
    check("midrst.addr",  32'(bus.o_addr),  32'd0);
    check("midrst.x",     32'(bus.o_x),     32'(ex_x(0)));
    tick();
    i_rst_n = 1'b1;
    tick();
    check_idle("midrst.after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
